if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined RV32I core.
- Owns the program counter and drives it to the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register for the decode stage.
- Handles decode-stage stalls, execute-stage redirects (branch/jump) and EBREAK halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (ADDI x0,x0,0) placed in IF/ID when invalid.
- EBREAK_INSTR, 32'h0010_0073, encoding that triggers HALT.

Ports:
- clk, input, 1, core clock; all state updates on rising edge.
- Resetn, input, 1, reset; synchronous, active-low.
- stall_i, input, 1, hold PC and IF/ID contents (load-use hazard from decode).
- redirect_valid_i, input, 1, branch/jump taken; flush and reload PC.
- redirect_pc_i, input, 32, redirect target.
- imem_pc_o, output, 32, address to instruction memory (= pc_q).
- imem_instr_i, input, 32, instruction returned combinationally for imem_pc_o.
- ifid_pc_o, output, 32, PC of the instruction held in IF/ID.
- ifid_pc_plus4_o, output, 32, ifid_pc_o + 4 (JAL/JALR link value).
- ifid_instr_o, output, 32, instruction held in IF/ID.
- ifid_valid_o, output, 1, IF/ID holds a real instruction.
- misalign_o, output, 1, one-cycle pulse: redirect target had bits [1:0] != 0.
- halted_o, output, 1, FSM is in HALT.

Behaviour:
- Reset (Resetn low at clock edge):
  - pc_q = RESET_PC, ifid_pc_o = 0, ifid_pc_plus4_o = 0, ifid_instr_o = NOP_INSTR, ifid_valid_o = 0.
  - misalign_o = 0, halted_o = 0, state = RUN.
  - Reset overrides every other input.
- imem_pc_o = pc_q combinationally; the memory returns data in the same cycle (zero-latency), so capture latency is 1 cycle.
- FSM has two states, RUN and HALT.
- Priority each cycle: reset > redirect > stall > normal.
- RUN, normal (no stall, no redirect):
  - IF/ID <= {pc_q, pc_q+4, imem_instr_i, valid=1}.
  - pc_q <= pc_q + 4, mod 2^32; wrap from 0xFFFF_FFFC to 0 is allowed.
  - If imem_instr_i == EBREAK_INSTR, the EBREAK is captured and valid, pc_q does not advance, and state becomes HALT.
- RUN, stall_i=1 and no redirect: pc_q and all IF/ID fields hold; ifid_valid_o holds its value.
- Redirect, in any state, also when stall_i=1:
  - pc_q <= {redirect_pc_i[31:2], 2'b00}.
  - IF/ID <= bubble (NOP_INSTR, valid=0; PC fields hold).
  - state <= RUN.
  - misalign_o <= |redirect_pc_i[1:0], cleared the following cycle.
- HALT:
  - pc_q holds; halted_o = 1.
  - Without stall, IF/ID <= bubble on the first HALT cycle and stays a bubble.
  - With stall, IF/ID holds, so the EBREAK is not lost.
  - Only a redirect or reset leaves HALT.
- imem_pc_o is never clipped; memory-side aliasing of high address bits is the memory's concern.
- Exactly one instruction enters IF/ID per non-stalled RUN cycle; no instruction is duplicated or skipped across a stall boundary.

Optional Feature:
- Macro: IF_STAGE_PERF_CNT_EN.
- When defined, adds three 32-bit outputs:
  - perf_fetch_o: counts valid captures.
  - perf_stall_o: counts cycles with stall_i=1 and no redirect.
  - perf_flush_o: counts redirect cycles.
- The counters clear on reset and wrap at 2^32.
- When undefined, the ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared package core_pkg holds NOP_INSTR, EBREAK_INSTR, the XLEN=32 constant, and the fetch_state_t enum {RUN, HALT}.
- One natural sub-module, ifid_reg: the IF/ID register with hold/flush/load controls. pc_q and the FSM stay in the top level.

Test Plan:
- Reset, then 4 free-running cycles with imem returning 0x00100093, 0x00200113, 0x00300193, 0x00400213 -> ifid_pc_o 0,4,8,12; ifid_valid_o=1 from cycle 1; imem_pc_o ends at 16.
- stall_i=1 for 3 cycles at pc_q=8 -> imem_pc_o stays 8, ifid_pc_o stays 4 with the same instruction; on release the next capture is pc 8.
- redirect_valid_i=1 with redirect_pc_i=0x40 while stall_i=1 -> next cycle imem_pc_o=0x40, ifid_valid_o=0, ifid_instr_o=0x13; following capture has ifid_pc_o=0x40.
- Redirect to 0x42 -> imem_pc_o=0x40, misalign_o high exactly one cycle.
- imem returns 0x00100073 at pc 0x10 -> EBREAK captured valid, halted_o=1, imem_pc_o stays 0x10, then bubbles; redirect to 0 -> halted_o=0 and fetch resumes at 0.
- Resetn low mid-stream at pc 0x20 with valid IF/ID -> next edge all outputs at reset values; with IF_STAGE_PERF_CNT_EN the counters read 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: data width, fixed encodings, fetch FSM states and the IF/ID payload.
package core_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [XLEN-1:0] EBREAK_INSTR = 32'h0010_0073;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register. Flush inserts a bubble and keeps the PC fields. Load captures a fetched instruction.
// With neither flush nor load, the register holds its value.
module ifid_reg
    import core_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic        clk,
    input  logic        Resetn,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    ifid_t q;

    always_ff @(posedge clk) begin
        if (!Resetn) begin
            q.pc       <= '0;
            q.pc_plus4 <= '0;
            q.instr    <= NOP;
            q.valid    <= 1'b0;
        end else if (flush_i) begin
            q.instr    <= NOP;
            q.valid    <= 1'b0;
        end else if (load_i) begin
            q.pc       <= pc_i;
            q.pc_plus4 <= pc_i + XLEN'(4);
            q.instr    <= instr_i;
            q.valid    <= 1'b1;
        end
    end

    assign pc_o       = q.pc;
    assign pc_plus4_o = q.pc_plus4;
    assign instr_o    = q.instr;
    assign valid_o    = q.valid;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns pc_q, feeds zero-latency imem, fills IF/ID, handles stall/redirect/EBREAK halt.
// Defining IF_STAGE_PERF_CNT_EN adds the fetch/stall/flush performance counters.
module if_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP          = NOP_INSTR,
    parameter logic [31:0] EBREAK       = EBREAK_INSTR
) (
    input  logic        clk,
    input  logic        Resetn,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc_plus4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic        misalign_o,
    output logic        halted_o
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_flush_o
`endif
);

    logic [XLEN-1:0] pc_q;
    fetch_state_t    state_q;
    logic            load_c;
    logic            flush_c;
    logic            ebreak_c;

    // Redirect beats stall. An unstalled HALT cycle keeps IF/ID filled with bubbles.
    always_comb begin
        load_c  = 1'b0;
        flush_c = 1'b0;
        if (redirect_valid_i) begin
            flush_c = 1'b1;
        end else if (!stall_i) begin
            if (state_q == RUN) load_c  = 1'b1;
            else                flush_c = 1'b1;
        end
    end

    assign ebreak_c = (imem_instr_i == EBREAK);

    always_ff @(posedge clk) begin
        if (!Resetn) begin
            pc_q       <= RESET_PC;
            state_q    <= RUN;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
            if (redirect_valid_i) begin
                pc_q    <= {redirect_pc_i[31:2], 2'b00};
                state_q <= RUN;
            end else if (load_c) begin
                if (ebreak_c) state_q <= HALT;
                else          pc_q    <= pc_q + XLEN'(4);
            end
        end
    end

    assign imem_pc_o = pc_q;
    assign halted_o  = (state_q == HALT);

    ifid_reg #(.NOP(NOP)) u_ifid_reg (
        .clk        (clk),
        .Resetn     (Resetn),
        .load_i     (load_c),
        .flush_i    (flush_c),
        .pc_i       (pc_q),
        .instr_i    (imem_instr_i),
        .pc_o       (ifid_pc_o),
        .pc_plus4_o (ifid_pc_plus4_o),
        .instr_o    (ifid_instr_o),
        .valid_o    (ifid_valid_o)
    );

`ifdef IF_STAGE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!Resetn) begin
            perf_fetch_o <= '0;
            perf_stall_o <= '0;
            perf_flush_o <= '0;
        end else begin
            if (load_c)                         perf_fetch_o <= perf_fetch_o + XLEN'(1);
            if (stall_i && !redirect_valid_i)   perf_stall_o <= perf_stall_o + XLEN'(1);
            if (redirect_valid_i)               perf_flush_o <= perf_flush_o + XLEN'(1);
        end
    end
`endif

endmodule
